// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: state encodings, default bit timing and data width.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_fifo_pkg;

    localparam int DATA_W           = 8;
    localparam int DEF_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY    = 3'd5
`endif
    } state_t;

    // Even parity: data plus parity bit must carry an even number of ones.
    function automatic logic even_parity_ok(input logic [DATA_W-1:0] d, input logic p);
        return ~(^d ^ p);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic show-ahead synchronous FIFO with full/empty flags and a registered drop (overrun) pulse.
// Pointers carry one extra wrap bit so full and empty are distinguished by comparison alone.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overrun = overrun_q;

    always_comb begin
        do_pop    = rd_en && !empty;
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
        do_push   = wr_en && (!full || do_pop);
        overrun_d = wr_en && !do_push;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        mem_d     = mem_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead FIFO read by the Main core.
// Define UART_RX_PARITY_EN to expect an even-parity bit and expose parity_err.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DEPTH        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              frame_err,
    output logic              overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    logic              sync1_q, rx_s_q;
    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              frame_err_q, frame_err_d;
    logic              push;
    logic              bit_done;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_d;
    logic              parity_err_q, parity_err_d;
    assign parity_err = parity_err_q;
`endif

    assign frame_err = frame_err_q;
    assign bit_done  = (timer_q == TW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                // Half a bit in: restarting the timer here aligns later samples to mid-bit.
                if (timer_q == TW'(CLKS_PER_BIT / 2 - 1)) begin
                    timer_d = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    timer_d   = '0;
                    shift_d   = {rx_s_q, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
`else
                    if (bit_cnt_q == 3'd7) state_d = S_STOP;
`endif
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    timer_d = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    timer_d = '0;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end else begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (even_parity_ok(shift_q, par_q)) push = 1'b1;
                        else                                parity_err_d = 1'b1;
`else
                        push = 1'b1;
`endif
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= rx;
            rx_s_q      <= sync1_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (shift_q),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .overrun (overrun)
    );

endmodule
